seg_scan_scheduler: RTL and testbench
=====================================

Name: seg_scan_scheduler

Overview:
- Drives the 4-digit, active-low seven-segment display.
- Holds one 32-bit frame buffer holding four segment bytes.
- Scans the digits left to right, with a blanking dead-time at the start of each digit slot to suppress ghosting.
- Shares the display between two frame producers: src1 has priority over src0. A new frame is accepted only in IDLE or at a full-scan boundary, so the display never tears.

Parameters:
- DIGIT_CYC, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); must be at least 2.
- BLANK_CYC, 1000, cycles at the start of each slot with all anodes off; must be less than DIGIT_CYC.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- enable  in  1  1 = scan the display; 0 = IDLE (display dark, buffer retained)
- src0_valid  in  1  low-priority producer has a frame
- src0_frame  in  32  low-priority frame: [31:24] leftmost digit ... [7:0] rightmost; each byte {dp,g..a}, active-low
- src0_ready  out  1  src0 transfer accepted this cycle when src0_valid is also high
- src1_valid  in  1  high-priority producer has a frame
- src1_frame  in  32  high-priority frame, same format as src0_frame
- src1_ready  out  1  src1 transfer accepted this cycle when src1_valid is also high
- seg  out  8  segment drive, active-low, bit7 = dp
- an  out  4  anode drive, active-low
- frame_start  out  1  one-cycle pulse on the first cycle of a slot-0 display
- owner  out  1  source of the most recently loaded frame (0 = src0, 1 = src1)

Behaviour:
- Reset:
  - seg=8'hFF, an=4'hF, frame_start=0, owner=0, src0_ready=0, src1_ready=0.
  - Buffer=32'hFFFF_FFFF; cnt=0, slot=0, state=IDLE.
  - Reset asserted mid-scan returns everything to these values at the next edge.
- States:
  - IDLE: entered from any state when enable=0.
  - BLANK: cnt < BLANK_CYC.
  - SHOW: cnt >= BLANK_CYC.
- Transitions:
  - IDLE -> BLANK with cnt=0, slot=0 when enable=1.
  - cnt counts 0..DIGIT_CYC-1, then wraps to 0 and slot increments.
  - slot 3 wraps to slot 0; this wrap point is the scan boundary (slot=3 and cnt=DIGIT_CYC-1).
- Output decode:
  - seg, an and frame_start are registered, with one-cycle latency from the (state, slot, cnt) that produced them.
  - IDLE/BLANK: an=4'hF, seg=8'hFF.
  - SHOW: slot 0 -> an=4'b0111, seg=buf[31:24]; slot 1 -> 4'b1011, buf[23:16]; slot 2 -> 4'b1101, buf[15:8]; slot 3 -> 4'b1110, buf[7:0].
- Handshake (ready is a combinational function of registered state and src1_valid only):
  - load_win = (state==IDLE) or scan boundary; forced 0 during RST.
  - src1_ready = load_win.
  - src0_ready = load_win and not src1_valid.
  - A transfer happens at the edge where valid and ready are both high; the buffer takes that frame and owner takes the source index.
  - Both sources valid: src1 wins, src0 is held off until the next window.
  - Valid outside a window: no transfer, buffer unchanged; the producer must hold valid and frame stable.
  - A frame loaded at the boundary is shown starting from the immediately following slot 0.
- frame_start: asserted for the single registered-output cycle corresponding to slot=0, cnt=BLANK_CYC.
- enable falling in any state: IDLE at the next edge, so one cycle later an=F and seg=FF. Re-enable always restarts at slot 0, cnt 0.
- Widths:
  - cnt width = clog2(DIGIT_CYC); slot is 2 bits.
  - All comparisons are unsigned; no other arithmetic.

Decomposition:
- Package seg_scan_pkg:
  - state enum {IDLE, BLANK, SHOW}
  - SEG_OFF=8'hFF, AN_OFF=4'hF
  - AN_SEL[0..3] = 0111, 1011, 1101, 1110
- Sub-module seg_scan_timer: cnt/slot counters. Outputs in_blank, boundary and slot; enable acts as a synchronous clear.
- Top level holds arbitration, the buffer and the output registers.

Test Plan (DIGIT_CYC=8, BLANK_CYC=2):
1. RST high for 2 cycles with both sources valid -> seg=FF, an=F, both readies 0, owner=0 throughout.
2. enable=0, src0_valid with frame 32'h9230_C0F8 -> src0_ready=1 the same cycle; then enable=1 -> per slot 2 cycles an=F, then 6 cycles each of an=0111/seg=92, an=1011/seg=30, an=1101/seg=C0, an=1110/seg=F8. frame_start pulses every 32 cycles.
3. Both valid across a boundary (src1 frame 32'hF9A4B0_99) -> src1_ready=1, src0_ready=0, owner=1; the next slot 0 shows seg=F9.
4. src0_valid raised during slot 1 -> src0_ready stays 0 until the boundary; seg keeps the old bytes for slots 1-3; the transfer occurs at the boundary.
5. enable dropped mid slot 2 -> next output cycle an=F, seg=FF; src0_ready goes high in IDLE; re-enable -> 2 blank cycles, then an=0111.
6. RST asserted mid-SHOW with a loaded buffer -> next outputs FF/F, owner=0; after enable, all digits show seg=FF.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan scheduler.
// Contents: scan state enum, blank segment/anode codes, per-slot anode select.
// All drive codes are active-low.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Indexed by slot: slot 0 is the leftmost digit.
  localparam logic [3:0][3:0] AN_SEL = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

endpackage

// File: rtl/seg_scan_timer.sv
// Digit-slot timer: cnt counts 0..DIGIT_CYC-1 per slot, slot walks 0..3.
// Ports: clk/rst (sync, active-high), enable (0 = clear to IDLE);
//   idle, in_blank, boundary (slot 3, last cycle), show_start (first SHOW cycle), slot.
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int DIGIT_CYC = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       idle,
  output logic       in_blank,
  output logic       boundary,
  output logic       show_start,
  output logic [1:0] slot
);

  localparam int CW = $clog2(DIGIT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYC - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      slot_q, slot_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      slot_d  = '0;
    end else if (state_q == IDLE) begin
      // Every (re)start begins a fresh scan at the leftmost digit.
      state_d = BLANK;
      cnt_d   = '0;
      slot_d  = '0;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        slot_d = slot_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      // BLANK/SHOW is purely a function of where cnt lands in the slot.
      state_d = (cnt_d < CNT_SHOW) ? BLANK : SHOW;
    end
  end

  assign idle       = (state_q == IDLE);
  assign in_blank   = (state_q == BLANK);
  assign boundary   = (state_q != IDLE) && (slot_q == 2'd3) && (cnt_q == CNT_LAST);
  assign show_start = (state_q == SHOW) && (cnt_q == CNT_SHOW);
  assign slot       = slot_q;

endmodule

// File: rtl/seg_scan_scheduler.sv
// Four-digit active-low seven-segment scanner with a two-source frame buffer.
// Ports: CLK/RST, enable, src0/src1 valid-frame-ready (src1 has priority),
//   seg/an/frame_start (registered, 1-cycle latency), owner of the last loaded frame.
module seg_scan_scheduler
  import seg_scan_pkg::*;
#(
  parameter int DIGIT_CYC = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        enable,
  input  logic        src0_valid,
  input  logic [31:0] src0_frame,
  output logic        src0_ready,
  input  logic        src1_valid,
  input  logic [31:0] src1_frame,
  output logic        src1_ready,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_start,
  output logic        owner
);

  logic       idle;
  logic       in_blank;
  logic       boundary;
  logic       show_start;
  logic [1:0] slot;
  logic       load_win;
  logic       showing;

  // Byte 3 ([31:24]) belongs to slot 0, so the byte index is ~slot.
  logic [3:0][7:0] frame_buf;

  seg_scan_timer #(
    .DIGIT_CYC (DIGIT_CYC),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk        (CLK),
    .rst        (RST),
    .enable     (enable),
    .idle       (idle),
    .in_blank   (in_blank),
    .boundary   (boundary),
    .show_start (show_start),
    .slot       (slot)
  );

  // Frames only land between full scans (or while dark) so a scan never tears.
  assign load_win   = !RST && (idle || boundary);
  assign src1_ready = load_win;
  assign src0_ready = load_win && !src1_valid;
  assign showing    = !idle && !in_blank;

  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_buf   <= {4{SEG_OFF}};
      owner       <= 1'b0;
      seg         <= SEG_OFF;
      an          <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      if (src1_valid && src1_ready) begin
        frame_buf <= src1_frame;
        owner     <= 1'b1;
      end else if (src0_valid && src0_ready) begin
        frame_buf <= src0_frame;
        owner     <= 1'b0;
      end

      if (showing) begin
        an  <= AN_SEL[slot];
        seg <= frame_buf[~slot];
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
      end

      frame_start <= show_start && (slot == 2'd0);
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler with DIGIT_CYC=8, BLANK_CYC=2.
// A position tracker (tpos = timer slot*8+cnt, -1 when dark) gives expected drive each cycle.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_seg_scan_scheduler;

  logic        CLK;
  logic        RST;
  logic        enable;
  logic        src0_valid;
  logic [31:0] src0_frame;
  logic        src0_ready;
  logic        src1_valid;
  logic [31:0] src1_frame;
  logic        src1_ready;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_start;
  logic        owner;

  int          errors = 0;
  int          checks = 0;
  int          tpos   = -1;
  logic [31:0] shown  = 32'hFFFF_FFFF;
  logic [3:0]  an_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  seg_scan_scheduler #(
    .DIGIT_CYC (8),
    .BLANK_CYC (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .enable      (enable),
    .src0_valid  (src0_valid),
    .src0_frame  (src0_frame),
    .src0_ready  (src0_ready),
    .src1_valid  (src1_valid),
    .src1_frame  (src1_frame),
    .src1_ready  (src1_ready),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start),
    .owner       (owner)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; outputs now reflect the timer position held before this edge.
  task automatic tick();
    int         p;
    int         s;
    logic [3:0] an_e;
    logic [7:0] seg_e;
    logic       fs_e;
    p = tpos;
    @(posedge CLK);
    #1;
    if (RST || !enable) tpos = -1;
    else                tpos = (p < 0) ? 0 : (p + 1) % 32;
    an_e  = 4'hF;
    seg_e = 8'hFF;
    fs_e  = 1'b0;
    if (!RST && p >= 0 && (p % 8) >= 2) begin
      s     = p / 8;
      an_e  = an_tab[s];
      seg_e = shown[(31 - 8 * s) -: 8];
      fs_e  = (p == 2);
    end
    chk("an", {28'd0, an}, {28'd0, an_e});
    chk("seg", {24'd0, seg}, {24'd0, seg_e});
    chk("frame_start", {31'd0, frame_start}, {31'd0, fs_e});
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (tpos != target && n < 64);
    if (tpos != target) begin
      errors++;
      $display("FAIL run_to: position %0d never reached (at %0d)", target, tpos);
    end
  endtask

  initial begin
    RST        = 1'b1;
    enable     = 1'b0;
    src0_valid = 1'b1;
    src0_frame = 32'h1234_5678;
    src1_valid = 1'b1;
    src1_frame = 32'h8765_4321;

    // 1: reset with both sources asserting
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_src0_ready", {31'd0, src0_ready}, 32'd0);
      chk("rst_src1_ready", {31'd0, src1_ready}, 32'd0);
      chk("rst_owner", {31'd0, owner}, 32'd0);
    end

    // 2: load src0 while idle, then scan two full frames
    RST        = 1'b0;
    src1_valid = 1'b0;
    src0_frame = 32'h9230_C0F8;
    #1;
    chk("idle_src0_ready", {31'd0, src0_ready}, 32'd1);
    tick();
    chk("idle_load_owner", {31'd0, owner}, 32'd0);
    shown      = 32'h9230_C0F8;
    src0_valid = 1'b0;
    enable     = 1'b1;
    run_to(31);
    run_to(29);

    // 3: both sources valid across the boundary, src1 wins
    src1_valid = 1'b1;
    src1_frame = 32'hF9A4_B099;
    src0_valid = 1'b1;
    src0_frame = 32'h1122_3344;
    #1;
    chk("mid_src1_ready", {31'd0, src1_ready}, 32'd0);
    chk("mid_src0_ready", {31'd0, src0_ready}, 32'd0);
    run_to(31);
    chk("bnd_src1_ready", {31'd0, src1_ready}, 32'd1);
    chk("bnd_src0_ready", {31'd0, src0_ready}, 32'd0);
    tick();
    chk("bnd_owner_src1", {31'd0, owner}, 32'd1);
    shown      = 32'hF9A4_B099;
    src1_valid = 1'b0;
    src0_valid = 1'b0;

    // 4: src0 raised in slot 1 waits for the boundary
    run_to(9);
    src0_valid = 1'b1;
    src0_frame = 32'hC0F9_A4B0;
    #1;
    chk("slot1_src0_ready", {31'd0, src0_ready}, 32'd0);
    run_to(20);
    chk("slot2_src0_ready", {31'd0, src0_ready}, 32'd0);
    run_to(31);
    chk("bnd2_src0_ready", {31'd0, src0_ready}, 32'd1);
    tick();
    chk("bnd2_owner_src0", {31'd0, owner}, 32'd0);
    shown      = 32'hC0F9_A4B0;
    src0_valid = 1'b0;

    // 5: enable dropped mid slot 2, idle load from src1, re-enable
    run_to(19);
    enable = 1'b0;
    tick();
    chk("off_src0_ready", {31'd0, src0_ready}, 32'd1);
    src1_valid = 1'b1;
    src1_frame = 32'h4F66_6D7D;
    #1;
    chk("off_src1_ready", {31'd0, src1_ready}, 32'd1);
    chk("off_src0_held", {31'd0, src0_ready}, 32'd0);
    tick();
    chk("off_owner_src1", {31'd0, owner}, 32'd1);
    shown      = 32'h4F66_6D7D;
    src1_valid = 1'b0;
    enable     = 1'b1;
    run_to(4);

    // 6: reset mid-SHOW clears buffer and owner
    run_to(5);
    RST = 1'b1;
    tick();
    chk("rst2_owner", {31'd0, owner}, 32'd0);
    chk("rst2_src0_ready", {31'd0, src0_ready}, 32'd0);
    shown = 32'hFFFF_FFFF;
    RST   = 1'b0;
    run_to(31);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
